// File: rtl/delta_scan_scheduler.sv
// Time-multiplexed delta-modulation comparator: scans one captured frame channel by
// channel against per-channel references and queues spike events in a small FIFO.
module delta_scan_scheduler #(
  parameter int NCH        = 4,
  parameter int DW         = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = $clog2(NCH),
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            sample_valid,
  input  logic [NCH*DW-1:0] sample_data,
  output logic            sample_ready,
  input  logic [DW-1:0]   threshold,
  input  logic            off_spike,
  input  logic            load_prev,
  input  logic [CW-1:0]   load_chan,
  input  logic [DW-1:0]   force_prev,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [CW-1:0]   ev_chan,
  output logic [1:0]      ev_spike,
  output logic            busy,
  output logic [7:0]      spike_count
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       ch_reg;
  logic [NCH*DW-1:0]   snap_reg;
  logic [NCH*DW-1:0]   prev_flat;
  logic [DW-1:0]       thr_reg;
  logic                off_reg;
  logic [7:0]          spike_count_reg;

  logic [CW+1:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]         count_reg;

  logic [DW-1:0]       d, p;
  logic [DW:0]         up_diff, down_diff;
  logic                is_up, is_down, need_push, fifo_full, pop, can_go, push, accept, last_ch;
  logic [1:0]          spike;

  assign sample_ready = (state_reg == IDLE) && en;
  assign accept       = sample_valid && sample_ready;
  assign busy         = (state_reg == SCAN);

  // Differences are taken one bit wider so they never wrap.
  assign d         = snap_reg[ch_reg*DW +: DW];
  assign p         = prev_flat[ch_reg*DW +: DW];
  assign up_diff   = {1'b0, d} - {1'b0, p};
  assign down_diff = {1'b0, p} - {1'b0, d};
  assign is_up     = (d > p) && (up_diff >= {1'b0, thr_reg});
  assign is_down   = (p > d) && (down_diff >= {1'b0, thr_reg});
  assign spike     = {is_down, is_up};
  assign need_push = (spike != 2'b00) || off_reg;

  assign fifo_full = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign ev_valid  = (count_reg != '0);
  assign pop       = ev_valid && ev_ready;
  // A full FIFO that is popping this cycle still has room for the push.
  assign can_go    = busy && en && (!need_push || !fifo_full || pop);
  assign push      = can_go && need_push;
  assign last_ch   = (ch_reg == CW'(NCH-1));

  assign ev_chan     = fifo_mem[rd_ptr_reg][CW+1:2];
  assign ev_spike    = fifo_mem[rd_ptr_reg][1:0];
  assign spike_count = spike_count_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SCAN;
      SCAN:    if (can_go && last_ch) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ch_reg          <= '0;
      snap_reg        <= '0;
      thr_reg         <= '0;
      off_reg         <= 1'b0;
      spike_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        ch_reg   <= '0;
        snap_reg <= sample_data;
        thr_reg  <= threshold;
        off_reg  <= off_spike;
      end else if (can_go) begin
        ch_reg <= ch_reg + 1'b1;
      end
      if (push && (spike != 2'b00) && (spike_count_reg != 8'hFF))
        spike_count_reg <= spike_count_reg + 8'd1;
    end
  end

  // Per-channel reference; a force-load in IDLE lands before the next scan reads it.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_prev
    logic [DW-1:0] prev_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        prev_reg <= '0;
      else if (can_go && (spike != 2'b00) && (ch_reg == CW'(gi)))
        prev_reg <= d;
      else if ((state_reg == IDLE) && load_prev && (load_chan == CW'(gi)))
        prev_reg <= force_prev;
    end
    assign prev_flat[gi*DW +: DW] = prev_reg;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {ch_reg, spike};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule
